apb_mux_n: RTL and testbench
============================

# apb_mux_n

Parametrised N-to-1 APB requester multiplexer with round-robin arbitration and an optional downstream timeout. It sits between several APB requesters (CPU, debug, DMA) and a single APB completer segment. It regenerates a clean SETUP/ACCESS sequence downstream from registered copies of the winning request. Losing requesters are held in their access phase with s_pready low until they win.

## Interface
Parameters:
- N_PORT, 2, number of upstream ports (2..8)
- ADDR_W, `P_ADDR_W`, address width
- DATA_W, `P_DATA_W`, data width
- STRB_W, `P_STRB_W`, write-strobe width (DATA_W/8)
- TIMEOUT, 0, ACCESS-phase cycle limit before forced error; 0 disables the timeout

Ports (vectors packed, port i occupies slice [i*W +: W]):
- pclk  in  1  the single clock for all logic
- preset  in  1  reset, synchronous, active-high
- s_psel  in  N_PORT  per-port select
- s_penable  in  N_PORT  per-port enable
- s_pwrite  in  N_PORT  per-port direction
- s_paddr  in  N_PORT*ADDR_W  per-port address
- s_pwdata  in  N_PORT*DATA_W  per-port write data
- s_pwstrb  in  N_PORT*STRB_W  per-port strobes
- s_pready  out  N_PORT  per-port ready
- s_prdata  out  N_PORT*DATA_W  per-port read data
- s_pslverr  out  N_PORT  per-port error
- m_psel, m_penable, m_pwrite  out  1  downstream control
- m_paddr  out  ADDR_W; m_pwdata  out  DATA_W; m_pwstrb  out  STRB_W
- m_pready, m_pslverr  in  1; m_prdata  in  DATA_W

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE:**
  - The request vector is s_psel.
  - If any bit is set, the arbiter grants the first requesting index after last_grant, searching ascending with wrap.
  - On grant, the FSM latches grant index, paddr, pwrite, pwdata and pwstrb, then goes to SETUP.
  - last_grant is updated to the granted index.
- **SETUP:** m_psel=1, m_penable=0, then go to ACCESS.
- **ACCESS:**
  - m_psel=1, m_penable=1.
  - When m_pready=1, the FSM captures m_prdata (reads only; writes capture 0) and m_pslverr, then goes to RESP.
  - If TIMEOUT>0 and the timeout counter reaches TIMEOUT, the FSM goes to RESP with captured prdata=0 and pslverr=1.
- **RESP:**
  - For the granted port only: s_pready=1, s_prdata=captured data, s_pslverr=captured error, for exactly one cycle.
  - m_psel=0, m_penable=0. Then go to IDLE.
- **Non-granted ports:** s_pready=0, s_prdata=0, s_pslverr=0 at all times.
- **Downstream signals outside SETUP/ACCESS:** m_paddr, m_pwdata, m_pwstrb and m_pwrite are 0.
- **Timeout counter:** clog2(TIMEOUT+1) bits. It clears on entry to ACCESS and increments each ACCESS cycle with m_pready=0.
- **Abort:** a timeout abandons the downstream transfer. The completer sees psel fall without pready.
- **Upstream requirement:** a requester keeps psel asserted and its signals stable until it sees s_pready. The mux never samples upstream s_penable.
- **Simultaneous requests:** exactly one grant, by round-robin order.
- **Request dropped after grant:** illegal per APB. The transfer completes downstream regardless.
- **Reset:**
  - State goes to IDLE, last_grant to N_PORT-1 (port 0 wins first), counter to 0.
  - All outputs are 0.
  - Reset mid-transfer drops m_psel on the next edge with no response issued.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from s_* to m_* or from m_* to s_*.
- **Minimum latency:**
  - Request seen in IDLE at cycle 0.
  - SETUP at cycle 1, ACCESS at cycle 2.
  - m_pready=1 in cycle 2 gives s_pready in cycle 3 (RESP); IDLE in cycle 4.
- **Back-to-back:** 4 cycles per transfer minimum. A requester holding psel across RESP re-arbitrates in the following IDLE cycle.
- **Wait states:** each downstream wait cycle adds one cycle.
- **Timeout:** RESP occurs TIMEOUT cycles after ACCESS entry.

## Structure
- Width defaults come from the shared amba_define header (P_ADDR_W, P_DATA_W, P_STRB_W).
- FSM state encoding is kept local to the module as localparams.
- One sub-module, rr_arbiter:
  - Parameter N.
  - Inputs: req[N], last[clog2 N], en.
  - Output: one-hot gnt[N] plus encoded index.
  - Purely combinational; last_grant is registered in apb_mux_n.

## Test plan
- **Single read:**
  - Stimulus: port0 reads 0x40; m_pready=1 immediately, m_prdata=0xDEADBEEF.
  - Response: m_psel rises cycle 1, m_penable cycle 2; s_pready[0]=1 with s_prdata[0]=0xDEADBEEF in cycle 3 only.
- **Round robin:**
  - Stimulus: ports 0 and 1 request continuously after reset.
  - Response: grants alternate 0,1,0,1. With N_PORT=4 and all requesting, order is 0,1,2,3,0.
- **Wait states and error:**
  - Stimulus: port1 writes 0x12345678 with strb 0xC to 0x100; m_pready held low 3 cycles, then high with m_pslverr=1.
  - Response: m_pwdata/m_pwstrb stable through ACCESS; s_pslverr[1]=1 with s_pready[1]; s_prdata[1]=0.
- **Timeout:**
  - Stimulus: TIMEOUT=8, m_pready stuck at 0.
  - Response: RESP 8 cycles after ACCESS entry with s_pslverr=1, s_prdata=0; m_psel falls. The next request is serviced normally.
- **Reset mid-ACCESS:**
  - Stimulus: preset high for one cycle.
  - Response: all outputs 0 next cycle; no s_pready pulse. The first post-reset simultaneous request from ports 0 and 1 grants port 0.
- **Isolation:**
  - Stimulus: throughout the above scenarios, monitor non-granted ports.
  - Response: s_pready, s_prdata and s_pslverr stay 0 on every non-granted port; assertion checks m_penable never rises without a prior SETUP cycle.

Source files
------------

// File: rtl/apb_mux_n_pkg.sv
// Shared widths and helpers for the N-to-1 APB requester multiplexer.
package apb_mux_n_pkg;

    localparam int P_ADDR_W = 32;
    localparam int P_DATA_W = 32;
    localparam int P_STRB_W = P_DATA_W / 8;

    // Index width for an n-entry selector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after 'last',
// searching upward with wrap-around.
module rr_arbiter
    import apb_mux_n_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand_s;
    logic [IW-1:0] idx_s;

    // Walk from last+N down to last+1 so the nearest requester after last overwrites the rest.
    always_comb begin
        cand_s = '0;
        idx_s  = '0;
        for (int k = N; k >= 1; k--) begin
            cand_s = IW'((int'(last) + k) % N);
            idx_s  = req[cand_s] ? cand_s : idx_s;
        end
        gnt = '0;
        if (en && (|req)) begin
            gnt[idx_s] = 1'b1;
        end else begin
            gnt = '0;
        end
        idx = idx_s;
    end

endmodule

// File: rtl/apb_mux_n.sv
// N-to-1 APB requester mux: round-robin arbitration, regenerated SETUP/ACCESS
// downstream, single-cycle response to the winner and optional ACCESS timeout.
module apb_mux_n
    import apb_mux_n_pkg::*;
#(
    parameter int N_PORT  = 2,
    parameter int ADDR_W  = P_ADDR_W,
    parameter int DATA_W  = P_DATA_W,
    parameter int STRB_W  = P_STRB_W,
    parameter int TIMEOUT = 0
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic [N_PORT-1:0]          s_psel,
    input  logic [N_PORT-1:0]          s_penable,
    input  logic [N_PORT-1:0]          s_pwrite,
    input  logic [N_PORT*ADDR_W-1:0]   s_paddr,
    input  logic [N_PORT*DATA_W-1:0]   s_pwdata,
    input  logic [N_PORT*STRB_W-1:0]   s_pwstrb,
    output logic [N_PORT-1:0]          s_pready,
    output logic [N_PORT*DATA_W-1:0]   s_prdata,
    output logic [N_PORT-1:0]          s_pslverr,
    output logic                       m_psel,
    output logic                       m_penable,
    output logic                       m_pwrite,
    output logic [ADDR_W-1:0]          m_paddr,
    output logic [DATA_W-1:0]          m_pwdata,
    output logic [STRB_W-1:0]          m_pwstrb,
    input  logic                       m_pready,
    input  logic                       m_pslverr,
    input  logic [DATA_W-1:0]          m_prdata
);

    localparam int IW    = idx_width(N_PORT);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [IW-1:0]       grant_r, grant_nxt_s;
    logic [IW-1:0]       last_grant_r, last_nxt_s;
    logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
    logic [DATA_W-1:0]   wdata_r, wdata_nxt_s;
    logic [STRB_W-1:0]   wstrb_r, wstrb_nxt_s;
    logic                write_r, write_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                timeout_hit_s;
    logic [DATA_W-1:0]   resp_data_s;
    logic                resp_err_s;
    logic                busy_nxt_s;

    logic [N_PORT-1:0]        arb_gnt_s;
    logic [IW-1:0]            arb_idx_s;

    logic [N_PORT-1:0]        s_pready_r, s_pready_nxt_s;
    logic [N_PORT*DATA_W-1:0] s_prdata_r, s_prdata_nxt_s;
    logic [N_PORT-1:0]        s_pslverr_r, s_pslverr_nxt_s;
    logic                     m_psel_r, m_penable_r, m_pwrite_r;
    logic [ADDR_W-1:0]        m_paddr_r;
    logic [DATA_W-1:0]        m_pwdata_r;
    logic [STRB_W-1:0]        m_pwstrb_r;

    // Upstream penable carries no information the mux needs; psel alone defines a request.
    logic unused_penable_s;
    assign unused_penable_s = ^s_penable;

    rr_arbiter #(.N(N_PORT)) u_arb (
        .req  (s_psel),
        .last (last_grant_r),
        .en   (state_r == ST_IDLE),
        .gnt  (arb_gnt_s),
        .idx  (arb_idx_s)
    );

    // Timeout fires in the last permitted wait cycle so RESP lands TIMEOUT cycles after ACCESS entry.
    always_comb begin
        timeout_hit_s = 1'b0;
        if (TIMEOUT > 0) begin
            timeout_hit_s = (int'(cnt_r) == TIMEOUT - 1) && !m_pready;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Next-state, request latch and response capture.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        last_nxt_s  = last_grant_r;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        wstrb_nxt_s = wstrb_r;
        write_nxt_s = write_r;
        cnt_nxt_s   = cnt_r;
        resp_data_s = '0;
        resp_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|arb_gnt_s) begin
                    state_nxt_s = ST_SETUP;
                    grant_nxt_s = arb_idx_s;
                    last_nxt_s  = arb_idx_s;
                    addr_nxt_s  = s_paddr[int'(arb_idx_s)*ADDR_W +: ADDR_W];
                    wdata_nxt_s = s_pwdata[int'(arb_idx_s)*DATA_W +: DATA_W];
                    wstrb_nxt_s = s_pwstrb[int'(arb_idx_s)*STRB_W +: STRB_W];
                    write_nxt_s = s_pwrite[arb_idx_s];
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
                cnt_nxt_s   = '0;
            end
            ST_ACCESS: begin
                if (m_pready) begin
                    state_nxt_s = ST_RESP;
                    resp_data_s = write_r ? '0 : m_prdata;
                    resp_err_s  = m_pslverr;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_RESP;
                    resp_data_s = '0;
                    resp_err_s  = 1'b1;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end else begin
                    state_nxt_s = ST_ACCESS;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decided from the next state.
    always_comb begin
        busy_nxt_s      = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
        s_pready_nxt_s  = '0;
        s_prdata_nxt_s  = '0;
        s_pslverr_nxt_s = '0;
        if ((state_r == ST_ACCESS) && (state_nxt_s == ST_RESP)) begin
            s_pready_nxt_s[grant_r]                         = 1'b1;
            s_prdata_nxt_s[int'(grant_r)*DATA_W +: DATA_W]  = resp_data_s;
            s_pslverr_nxt_s[grant_r]                        = resp_err_s;
        end else begin
            s_pready_nxt_s  = '0;
            s_prdata_nxt_s  = '0;
            s_pslverr_nxt_s = '0;
        end
    end

    // State, request latch and registered outputs.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= IW'(N_PORT - 1);
            addr_r       <= '0;
            wdata_r      <= '0;
            wstrb_r      <= '0;
            write_r      <= 1'b0;
            cnt_r        <= '0;
            s_pready_r   <= '0;
            s_prdata_r   <= '0;
            s_pslverr_r  <= '0;
            m_psel_r     <= 1'b0;
            m_penable_r  <= 1'b0;
            m_pwrite_r   <= 1'b0;
            m_paddr_r    <= '0;
            m_pwdata_r   <= '0;
            m_pwstrb_r   <= '0;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_nxt_s;
            addr_r       <= addr_nxt_s;
            wdata_r      <= wdata_nxt_s;
            wstrb_r      <= wstrb_nxt_s;
            write_r      <= write_nxt_s;
            cnt_r        <= cnt_nxt_s;
            s_pready_r   <= s_pready_nxt_s;
            s_prdata_r   <= s_prdata_nxt_s;
            s_pslverr_r  <= s_pslverr_nxt_s;
            m_psel_r     <= busy_nxt_s;
            m_penable_r  <= (state_nxt_s == ST_ACCESS);
            m_pwrite_r   <= busy_nxt_s ? write_nxt_s : 1'b0;
            m_paddr_r    <= busy_nxt_s ? addr_nxt_s  : '0;
            m_pwdata_r   <= busy_nxt_s ? wdata_nxt_s : '0;
            m_pwstrb_r   <= busy_nxt_s ? wstrb_nxt_s : '0;
        end
    end

    assign s_pready  = s_pready_r;
    assign s_prdata  = s_prdata_r;
    assign s_pslverr = s_pslverr_r;
    assign m_psel    = m_psel_r;
    assign m_penable = m_penable_r;
    assign m_pwrite  = m_pwrite_r;
    assign m_paddr   = m_paddr_r;
    assign m_pwdata  = m_pwdata_r;
    assign m_pwstrb  = m_pwstrb_r;

endmodule

// File: tb/tb_apb_mux_n.sv
// Self-checking bench for apb_mux_n: 4 ports, TIMEOUT=8, directed scenarios plus
// randomized traffic checked against a round-robin / protocol reference model.
module tb_apb_mux_n;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic              pclk = 1'b0;
    logic              preset;
    logic [NP-1:0]     s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
    logic [NP*AW-1:0]  s_paddr;
    logic [NP*DW-1:0]  s_pwdata, s_prdata;
    logic [NP*SW-1:0]  s_pwstrb;
    logic              m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [AW-1:0]     m_paddr;
    logic [DW-1:0]     m_pwdata, m_prdata;
    logic [SW-1:0]     m_pwstrb;

    int checks   = 0;
    int failures = 0;
    int last_m   = NP - 1;
    logic prev_psel = 1'b0;
    logic prev_pen  = 1'b0;

    always #5 pclk = ~pclk;
    assign s_penable = s_psel;

    apb_mux_n #(
        .N_PORT(NP), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .TIMEOUT(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb),
        .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb),
        .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Round-robin reference: first requester strictly after the last winner, wrapping.
    function automatic int rr_model(input logic [NP-1:0] r);
        for (int k = 1; k <= NP; k++) begin
            if (r[(last_m + k) % NP]) return (last_m + k) % NP;
        end
        return 0;
    endfunction

    task automatic set_port(input int i, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
        s_pwrite[i]          = wr;
        s_paddr[i*AW +: AW]  = a;
        s_pwdata[i*DW +: DW] = d;
        s_pwstrb[i*SW +: SW] = s;
    endtask

    task automatic rand_idle_ports();
        for (int i = 0; i < NP; i++) begin
            if (!s_psel[i]) begin
                set_port(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            end
        end
    endtask

    task automatic reset_dut();
        preset = 1'b1;
        s_psel = '0;
        m_pready = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        last_m = NP - 1;
    endtask

    // Called #1 after an edge with the DUT in IDLE; returns one cycle into the following IDLE.
    task automatic run_xfer(input logic [NP-1:0] req, input int waits, input logic err,
                            input logic [DW-1:0] rd, input bit stuck, output int got_w);
        int w, n_acc, exp_acc;
        bit done;
        logic [DW-1:0] exp_rd;
        logic exp_err;
        chk("idle_psel", m_psel, 0);
        chk("idle_paddr", m_paddr, 0);
        chk("idle_pwdata", m_pwdata, 0);
        s_psel = s_psel | req;
        w = rr_model(s_psel);
        m_pready = 1'b0;
        @(posedge pclk); #1;
        chk("setup_psel", m_psel, 1);
        chk("setup_penable", m_penable, 0);
        chk("setup_paddr", m_paddr, s_paddr[w*AW +: AW]);
        chk("setup_pwrite", m_pwrite, s_pwrite[w]);
        chk("setup_pwdata", m_pwdata, s_pwdata[w*DW +: DW]);
        chk("setup_pwstrb", m_pwstrb, s_pwstrb[w*SW +: SW]);
        n_acc = 0;
        done  = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(posedge pclk); #1;
            if (s_pready != '0) begin
                done = 1'b1;
            end else begin
                chk("acc_psel", m_psel, 1);
                chk("acc_penable", m_penable, 1);
                chk("acc_paddr", m_paddr, s_paddr[w*AW +: AW]);
                chk("acc_pwdata", m_pwdata, s_pwdata[w*DW +: DW]);
                chk("acc_pwstrb", m_pwstrb, s_pwstrb[w*SW +: SW]);
                m_pready = (n_acc >= waits) && !stuck;
                m_prdata = m_pready ? rd : $urandom;
                m_pslverr = m_pready ? err : 1'($urandom_range(0, 1));
                n_acc++;
            end
        end
        exp_acc = stuck ? TO : waits + 1;
        exp_rd  = (s_pwrite[w] || stuck) ? '0 : rd;
        exp_err = stuck ? 1'b1 : err;
        chk("resp_seen", done, 1);
        chk("access_cycles", n_acc, exp_acc);
        chk("resp_pready", s_pready, 64'(1) << w);
        chk("resp_rdata", s_prdata[w*DW +: DW], exp_rd);
        chk("resp_err", s_pslverr[w], exp_err);
        chk("resp_psel", m_psel, 0);
        chk("resp_paddr", m_paddr, 0);
        got_w = -1;
        for (int i = 0; i < NP; i++) begin
            if (s_pready[i]) got_w = i;
        end
        s_psel[w] = 1'b0;
        m_pready  = 1'b0;
        last_m    = w;
        @(posedge pclk); #1;
        chk("post_resp_pready", s_pready, 0);
    endtask

    // Isolation and SETUP-before-ACCESS monitor, sampled on the falling edge.
    always @(negedge pclk) begin
        for (int i = 0; i < NP; i++) begin
            if (!s_pready[i]) begin
                chk("iso_rdata", s_prdata[i*DW +: DW], 0);
                chk("iso_err", s_pslverr[i], 0);
            end
        end
        chk("pready_onehot", ($countones(s_pready) <= 1), 1);
        if (m_penable && !prev_pen) begin
            chk("penable_after_setup", {prev_psel, prev_pen}, 2'b10);
        end
        prev_psel <= m_psel;
        prev_pen  <= m_penable;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        preset    = 1'b1;
        s_psel    = '0;
        s_pwrite  = '0;
        s_paddr   = '0;
        s_pwdata  = '0;
        s_pwstrb  = '0;
        m_pready  = 1'b0;
        m_prdata  = '0;
        m_pslverr = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_m_psel", m_psel, 0);
        chk("rst_m_penable", m_penable, 0);
        chk("rst_m_paddr", m_paddr, 0);
        chk("rst_s_pready", s_pready, 0);
        chk("rst_s_prdata", s_prdata, 0);
        preset = 1'b0;

        // Single read from port 0
        set_port(0, 1'b0, 32'h0000_0040, 32'h1111_2222, 4'hF);
        run_xfer(4'b0001, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, w);
        chk("single_read_grant", w, 0);

        // Write with wait states and a slave error
        set_port(1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'hC);
        run_xfer(4'b0010, 3, 1'b1, 32'hA5A5_A5A5, 1'b0, w);
        chk("wait_err_grant", w, 1);

        // Timeout, then a normal transfer
        set_port(2, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        run_xfer(4'b0100, 0, 1'b0, 32'h5555_AAAA, 1'b1, w);
        set_port(3, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
        run_xfer(4'b1000, 1, 1'b0, 32'hCAFE_F00D, 1'b0, w);
        chk("after_timeout_grant", w, 3);

        // Ready in the last permitted cycle beats the timeout
        set_port(0, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
        run_xfer(4'b0001, TO - 1, 1'b0, 32'h0BAD_F00D, 1'b0, w);

        // Two continuous requesters after reset alternate 0,1,0,1
        reset_dut();
        for (int j = 0; j < 4; j++) begin
            rand_idle_ports();
            run_xfer(4'b0011, 0, 1'b0, $urandom, 1'b0, w);
            chk("rr2_order", w, j % 2);
        end

        // Four continuous requesters after reset: 0,1,2,3,0
        reset_dut();
        for (int j = 0; j < 5; j++) begin
            rand_idle_ports();
            run_xfer(4'b1111, 1, 1'b0, $urandom, 1'b0, w);
            chk("rr4_order", w, j % 4);
        end

        // Reset in the middle of ACCESS
        s_psel = '0;
        set_port(2, 1'b1, 32'h0000_0208, 32'hFFFF_0000, 4'h3);
        s_psel = 4'b0100;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        chk("midrst_in_access", m_penable, 1);
        preset = 1'b1;
        s_psel = '0;
        @(posedge pclk); #1;
        preset = 1'b0;
        last_m = NP - 1;
        chk("midrst_psel", m_psel, 0);
        chk("midrst_penable", m_penable, 0);
        chk("midrst_paddr", m_paddr, 0);
        chk("midrst_pwdata", m_pwdata, 0);
        chk("midrst_pwstrb", m_pwstrb, 0);
        chk("midrst_pwrite", m_pwrite, 0);
        chk("midrst_pready", s_pready, 0);
        for (int j = 0; j < 3; j++) begin
            @(posedge pclk); #1;
            chk("midrst_quiet_pready", s_pready, 0);
            chk("midrst_quiet_psel", m_psel, 0);
        end
        rand_idle_ports();
        run_xfer(4'b0011, 0, 1'b0, $urandom, 1'b0, w);
        chk("post_reset_grant", w, 0);

        // Randomized traffic
        for (int j = 0; j < 40; j++) begin
            rand_idle_ports();
            run_xfer(4'($urandom_range(1, 15)), $urandom_range(0, TO - 1),
                     1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0), w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
